// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and small helpers used by the
// arbiter top and its round-robin picker.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RSP_OKAY  = 2'b00,
    RSP_ERROR = 2'b01,
    RSP_RETRY = 2'b10,
    RSP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Fixed beat count of a burst; SINGLE and undefined-length INCR report 1.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: return 5'd4;
      3'd4, 3'd5: return 5'd8;
      3'd6, 3'd7: return 5'd16;
      default:    return 5'd1;
    endcase
  endfunction

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration-side AHB signal bundle: requests and muxed bus status towards
// the arbiter, grant and ownership back to the masters, mux and slaves.
interface ahb_arbiter_if #(
  parameter int NMST = 4
);
  logic [NMST-1:0] HBUSREQ;
  logic [NMST-1:0] HLOCK;
  logic [1:0]      HTRANS;
  logic [2:0]      HBURST;
  logic            HREADY;
  logic [1:0]      HRESP;
  logic [15:0]     HSPLIT;
  logic [NMST-1:0] HGRANT;
  logic [3:0]      HMASTER;
  logic            HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, with wrap,
// returned one-hot together with a valid flag.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [3:0]   i_ptr,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);
  int w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int off = 1; off <= N; off++) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_valid && (|(i_req & (N'(1) << w_idx)))) begin
        o_grant = N'(1) << w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// Central AHB arbiter: round-robin grant with fixed-burst and lock protection,
// SPLIT masking, and HMASTER/HMASTLOCK handoff one HREADY cycle behind grant.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NMST = 4,
  parameter int DEF  = 0
) (
  input logic         HCLK,
  input logic         HRST_N,
  ahb_arbiter_if.slave bus
);
  localparam logic [NMST-1:0] DEF_OH = NMST'(1) << DEF;

  arb_state_e      r_state;
  logic [3:0]      r_count;
  logic [NMST-1:0] r_mask;
  logic [3:0]      r_ptr;
  logic [NMST-1:0] r_grant;
  logic [3:0]      r_master;
  logic            r_mastlock;

  logic [NMST-1:0] w_elig;
  logic [NMST-1:0] w_pick_oh;
  logic            w_pick_valid;
  logic [NMST-1:0] w_mst_oh;
  logic [NMST-1:0] w_next_grant;
  logic [NMST-1:0] w_split_set;
  logic [NMST-1:0] w_split_rel;
  logic            w_lock_hold;
  logic            w_grant_masked;
  logic            w_burst_start;
  logic            w_rearb;
  logic [4:0]      w_len;
  logic            w_unused_hsplit;

  assign w_elig         = bus.HBUSREQ & ~r_mask;
  assign w_mst_oh       = NMST'(1) << r_master;
  assign w_grant_masked = |(r_grant & r_mask);
  assign w_lock_hold    = r_mastlock && (|(bus.HLOCK & w_mst_oh)) && !(|(r_mask & w_mst_oh));
  assign w_len          = burst_len(bus.HBURST);
  assign w_burst_start  = (bus.HTRANS == TR_NONSEQ) && (w_len > 5'd1) && !w_grant_masked;
  assign w_unused_hsplit = ^bus.HSPLIT;

  rr_pick #(.N(NMST)) u_rr_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_oh),
    .o_valid (w_pick_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NMST; gi++) begin : g_split
      assign w_split_set[gi] = (bus.HRESP == RSP_SPLIT) && !bus.HREADY && (r_master == 4'(gi));
      assign w_split_rel[gi] = bus.HSPLIT[gi];
    end
  endgenerate

  // A live lock beats round-robin; an empty eligible set parks on the default master.
  always_comb begin
    w_next_grant = DEF_OH;
    if (w_lock_hold)       w_next_grant = w_mst_oh;
    else if (w_pick_valid) w_next_grant = w_pick_oh;
  end

  always_comb begin
    w_rearb = 1'b0;
    if (bus.HREADY) begin
      if (r_state == ST_ARB) w_rearb = !w_burst_start;
      else w_rearb = ((bus.HTRANS == TR_SEQ) && (r_count <= 4'd1)) ||
                     (bus.HTRANS == TR_IDLE) || (bus.HTRANS == TR_NONSEQ);
    end
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      r_state    <= ST_ARB;
      r_count    <= '0;
      r_mask     <= '0;
      r_ptr      <= 4'(DEF);
      r_grant    <= DEF_OH;
      r_master   <= 4'(DEF);
      r_mastlock <= 1'b0;
    end else begin
      // Set listed last so it wins over a same-cycle release.
      r_mask <= (r_mask & ~w_split_rel) | w_split_set;
      if (bus.HREADY) begin
        r_master   <= oh2idx(16'(r_grant));
        r_mastlock <= (|(bus.HLOCK & r_grant)) && !w_grant_masked;
        if (w_rearb) begin
          r_grant <= w_next_grant;
          r_ptr   <= oh2idx(16'(w_next_grant));
        end
        case (r_state)
          ST_ARB: begin
            if (w_burst_start) begin
              r_state <= ST_BURST;
              r_count <= 4'(w_len - 5'd1);
            end
          end
          ST_BURST: begin
            if (bus.HTRANS == TR_SEQ) begin
              if (r_count <= 4'd1) begin
                r_state <= ST_ARB;
                r_count <= '0;
              end else begin
                r_count <= r_count - 4'd1;
              end
            end else if (bus.HTRANS != TR_BUSY) begin
              r_state <= ST_ARB;
              r_count <= '0;
            end
          end
          default: r_state <= ST_ARB;
        endcase
      end else if ((r_state == ST_BURST) && (bus.HRESP != RSP_OKAY)) begin
        r_state <= ST_ARB;
        r_count <= '0;
      end
    end
  end

  assign bus.HGRANT    = r_grant;
  assign bus.HMASTER   = r_master;
  assign bus.HMASTLOCK = r_mastlock;
endmodule
